cypher_num_feeder: RTL
======================

# cypher_num_feeder

Upstream feeder for the cypher detector's digit input. It accepts 16-bit digit words from a producer through a valid/ready handshake and buffers them in a small FIFO. It then serializes each word into a gap-free stream of 4-bit digits, most significant nibble first, presented on `num` with `read` asserted. Its `num`/`read` outputs connect directly to the detector's `num`/`read` inputs, and it keeps a saturating count of digits emitted.

## Interface
- `DEPTH`, 4: FIFO depth in words; power of two, ≥2.
- `WORD_W`, 16: input word width.
- `NUM_W`, 4: digit width; `WORD_W` must be a multiple of `NUM_W`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `word_in` in WORD_W: digit word; bits [15:12] are emitted first.
- `word_valid` in 1: producer offers `word_in` this cycle.
- `word_ready` out 1: combinational, equals `!full && !reset`; a word transfers on an edge where `word_valid && word_ready`.
- `flush` in 1: synchronous clear of FIFO and serializer.
- `num` out NUM_W: registered current digit.
- `read` out 1: registered; high exactly when `num` holds a valid digit.
- `count` out 8: registered digits-emitted counter; saturates at 255.
- `empty` out 1: FIFO holds 0 words.
- `full` out 1: FIFO holds DEPTH words.

## Operation
- Reset values: `num`=0, `read`=0, `count`=0, `empty`=1, `full`=0, FIFO pointers 0, state IDLE, nibble index 0.
- FIFO: push on accepted transfer, pop when the serializer loads.
  - Occupancy is tracked with a counter of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - Push and pop on the same edge leave occupancy unchanged.
  - Push is refused while full, even if a pop occurs on the same edge.
- Serializer state machine, states IDLE and SHIFT:
  - IDLE, FIFO non-empty: pop the head into the shift register. Set `num`=word[15:12], `read`=1, index=0, and go to SHIFT.
  - IDLE, FIFO empty: `read`=0; `num` holds its last value.
  - SHIFT, index < NIBBLES-1: emit the next nibble, `read`=1, index+1.
  - SHIFT, index == NIBBLES-1, FIFO non-empty: pop the next word and emit its [15:12] on the following edge. There is no bubble between words.
  - SHIFT, index == NIBBLES-1, FIFO empty: go to IDLE and set `read`=0.
- `count` increments on every edge that leaves `read`=1, and stays at 255 once reached.
- `flush` priority is reset > flush > push/pop.
  - A flush edge empties the FIFO, drops any partially sent word, forces IDLE, and sets `read`=0.
  - A word offered on a flush edge is discarded.
  - `count` is not cleared by flush.
- Reset mid-word: outputs return to reset values immediately; no partial word resumes.

## Timing
- Latency with the FIFO empty and the serializer IDLE:
  - Word accepted at edge N.
  - First digit (`read`=1, `num`=word[15:12]) is registered at edge N+1.
  - The last digit is registered at edge N+4.
  - `read` falls at edge N+5 if no further word is available.
- Throughput: one digit per cycle, i.e. one word per NIBBLES cycles, sustained indefinitely when words arrive at least that fast.
- `word_ready` reflects `full` within the same cycle; `full`/`empty` are derived from the registered occupancy.
- No combinational path from `word_valid` to any output.

## Structure
- Shared package `cypher_pkg` holds:
  - constants `NUM_W`=4, `WORD_W`=16, `NIBBLES`=`WORD_W/NUM_W`, `COUNT_W`=8;
  - the serializer state typedef (IDLE, SHIFT).
- One sub-module, `nibble_fifo`: parameterised synchronous FIFO with push/pop/flush and `full`/`empty`/occupancy outputs.
- The top level contains the serializer state machine, the shift register, the index, and the counter.

## Test plan
- Reset, then a single word 0x5574: `num`=5,5,7,4 on 4 consecutive edges with `read`=1 on each; then `read`=0; `count`=4.
- Words 0x5574 and 0x2063 offered back to back: 8 digits 5,5,7,4,2,0,6,3 with `read` continuously high and no gap; `count`=8.
- `word_valid` held high with 6 distinct words while the serializer drains: `word_ready` drops when occupancy reaches 4. The held word is accepted once a pop frees a slot. All 6 words are emitted in order; none is lost or duplicated.
- Flush asserted after the 2nd digit of 0x5574, with 0x2063 queued: next edge `read`=0 and `empty`=1. No further digits appear; `count`=2 is retained.
- Reset asserted mid-word: outputs return to reset values asynchronously. After release, a new word 0x0102 emits 0,1,0,2 normally.
- 70 words streamed: `count` saturates at 255 and stays there while `read` keeps toggling correctly.

Source files
------------

// File: rtl/cypher_num_feeder_pkg.sv
// Shared constants, serializer state type and counter helper for the cypher digit feeder.
package cypher_pkg;

    localparam int unsigned NUM_W   = 4;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned NIBBLES = WORD_W / NUM_W;
    localparam int unsigned COUNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/cypher_num_feeder_if.sv
// Producer-side word handshake into the digit feeder.
interface cypher_num_feeder_if
    import cypher_pkg::*;
#(
    parameter int unsigned W = WORD_W
);

    logic [W-1:0] word_in;
    logic         word_valid;
    logic         word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);

endinterface

// File: rtl/cypher_num_feeder_nibble_fifo.sv
// Synchronous word FIFO with synchronous flush; occupancy counter disambiguates full/empty.
module nibble_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      occ_q;
    logic             push_d;
    logic             pop_d;

    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign empty     = (occ_q == '0);
    assign occupancy = occ_q;
    assign dout      = mem_q[rd_q];

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign push_d = push && !full && !flush;
    assign pop_d  = pop && !empty && !flush;

    always_ff @(posedge clock) begin
        if (push_d) begin
            mem_q[wr_q] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push_d) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_d) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_d, pop_d})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: rtl/cypher_num_feeder.sv
// Buffers digit words and serializes them MSB-nibble first onto num/read with no inter-word bubble.
module cypher_num_feeder
    import cypher_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WORD_W = cypher_pkg::WORD_W,
    parameter int unsigned NUM_W  = cypher_pkg::NUM_W
) (
    input  logic                 clock,
    input  logic                 reset,
    cypher_num_feeder_if.slave   bus,
    input  logic                 flush,
    output logic [NUM_W-1:0]     num,
    output logic                 read,
    output logic [COUNT_W-1:0]   count,
    output logic                 empty,
    output logic                 full
);

    localparam int unsigned NIB   = WORD_W / NUM_W;
    localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    state_t              state_q;
    logic [WORD_W-1:0]   shift_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_W-1:0]    num_q;
    logic                read_q;
    logic [COUNT_W-1:0]  count_q;

    logic [WORD_W-1:0]   head;
    logic [$clog2(DEPTH):0] occ;
    logic                fifo_full;
    logic                fifo_empty;
    logic                has_word;
    logic                push_d;
    logic                load_d;

    assign bus.word_ready = !fifo_full && !reset;
    assign push_d         = bus.word_valid && bus.word_ready && !flush;
    assign has_word       = (occ != '0);
    // Loading on the last nibble of the current word is what keeps the stream gap-free.
    assign load_d         = !flush && has_word && ((state_q == IDLE) || (idx_q == LAST));

    nibble_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (push_d),
        .pop       (load_d),
        .din       (bus.word_in),
        .dout      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .occupancy (occ)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            read_q  <= 1'b0;
            count_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            read_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_d) begin
                        num_q   <= head[WORD_W-1 -: NUM_W];
                        shift_q <= head << NUM_W;
                        idx_q   <= '0;
                        read_q  <= 1'b1;
                        count_q <= sat_inc(count_q);
                        state_q <= SHIFT;
                    end else begin
                        read_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (idx_q != LAST) begin
                        num_q   <= shift_q[WORD_W-1 -: NUM_W];
                        shift_q <= shift_q << NUM_W;
                        idx_q   <= idx_q + 1'b1;
                        read_q  <= 1'b1;
                        count_q <= sat_inc(count_q);
                    end else if (load_d) begin
                        num_q   <= head[WORD_W-1 -: NUM_W];
                        shift_q <= head << NUM_W;
                        idx_q   <= '0;
                        read_q  <= 1'b1;
                        count_q <= sat_inc(count_q);
                    end else begin
                        read_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign num   = num_q;
    assign read  = read_q;
    assign count = count_q;
    assign empty = fifo_empty;
    assign full  = fifo_full;

endmodule
